// File: rtl/pixel_stream_loader.sv
// Byte-stream front end for the WS2812 pixel RAM: frames R,G,B byte triplets into pixels,
// scales them by a global brightness and writes them to sequential LED addresses.
module pixel_stream_loader #(
  parameter int LED_COUNT  = 60,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  pixel_clk_i,
  input  logic                  rst_n_i,
  input  logic [7:0]            byte_i,
  input  logic                  byte_valid_i,
  output logic                  byte_ready_o,
  input  logic                  sof_i,
  input  logic [7:0]            brightness_i,
  output logic [7:0]            pixel_r_o,
  output logic [7:0]            pixel_g_o,
  output logic [7:0]            pixel_b_o,
  output logic [ADDR_WIDTH-1:0] led_address_o,
  output logic                  led_address_valid_o,
  output logic                  frame_done_o,
  output logic                  overflow_o,
  output logic                  sync_err_o
);

  // The index needs one extra bit so it can saturate at LED_COUNT.
  localparam int IDX_W = ADDR_WIDTH + 1;
  localparam logic [IDX_W-1:0] IDX_LIMIT = IDX_W'(LED_COUNT);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(LED_COUNT - 1);

  typedef enum logic [1:0] {
    PH_R = 2'd0,
    PH_G = 2'd1,
    PH_B = 2'd2
  } phase_e;

  // Handshake: a byte is taken on every edge where byte_valid_i && byte_ready_o;
  // ready rises on the first edge after reset release and never drops again.
  logic                  ready_q;
  logic                  accept;

  phase_e                phase_q, phase_d;
  logic                  synced_q, synced_d;
  logic [7:0]            red_q, red_d;
  logic [7:0]            green_q, green_d;
  logic [IDX_W-1:0]      index_q, index_d;
  logic                  overflow_q, overflow_d;
  logic                  sync_err_q, sync_err_d;
  logic                  launch;

  logic                  s0_valid_q;
  logic [7:0]            s0_r_q, s0_g_q, s0_b_q, s0_bright_q;
  logic [ADDR_WIDTH-1:0] s0_addr_q;
  logic                  s0_last_q;

  logic                  s1_valid_q;
  logic [15:0]           s1_r_q, s1_g_q, s1_b_q;
  logic [ADDR_WIDTH-1:0] s1_addr_q;
  logic                  s1_last_q;

  logic                  out_valid_q, out_done_q;
  logic [7:0]            out_r_q, out_g_q, out_b_q;
  logic [ADDR_WIDTH-1:0] out_addr_q;

  function automatic logic [15:0] scale(input logic [7:0] c, input logic [7:0] br);
    return {8'd0, c} * ({8'd0, br} + 16'd1);
  endfunction

  assign accept = byte_valid_i && ready_q;

  always_comb begin
    phase_d    = phase_q;
    synced_d   = synced_q;
    red_d      = red_q;
    green_d    = green_q;
    index_d    = index_q;
    overflow_d = overflow_q;
    sync_err_d = 1'b0;
    launch     = 1'b0;
    if (accept) begin
      if (sof_i) begin
        // A start-of-frame byte is always the red byte of LED 0, even mid-pixel.
        sync_err_d = synced_q && (phase_q != PH_R);
        synced_d   = 1'b1;
        phase_d    = PH_G;
        red_d      = byte_i;
        index_d    = '0;
        overflow_d = 1'b0;
      end else if (synced_q) begin
        case (phase_q)
          PH_R: begin
            red_d   = byte_i;
            phase_d = PH_G;
          end
          PH_G: begin
            green_d = byte_i;
            phase_d = PH_B;
          end
          PH_B: begin
            phase_d = PH_R;
            if (index_q < IDX_LIMIT) begin
              launch  = 1'b1;
              index_d = index_q + IDX_W'(1);
            end else begin
              overflow_d = 1'b1;
            end
          end
          default: phase_d = PH_R;
        endcase
      end
    end
  end

  always_ff @(posedge pixel_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ready_q    <= 1'b0;
      phase_q    <= PH_R;
      synced_q   <= 1'b0;
      red_q      <= '0;
      green_q    <= '0;
      index_q    <= '0;
      overflow_q <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      ready_q    <= 1'b1;
      phase_q    <= phase_d;
      synced_q   <= synced_d;
      red_q      <= red_d;
      green_q    <= green_d;
      index_q    <= index_d;
      overflow_q <= overflow_d;
      sync_err_q <= sync_err_d;
    end
  end

  // Launch register captures the completed pixel and the brightness seen with its blue byte.
  always_ff @(posedge pixel_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s0_valid_q  <= 1'b0;
      s0_r_q      <= '0;
      s0_g_q      <= '0;
      s0_b_q      <= '0;
      s0_bright_q <= '0;
      s0_addr_q   <= '0;
      s0_last_q   <= 1'b0;
    end else begin
      s0_valid_q <= launch;
      if (launch) begin
        s0_r_q      <= red_q;
        s0_g_q      <= green_q;
        s0_b_q      <= byte_i;
        s0_bright_q <= brightness_i;
        s0_addr_q   <= index_q[ADDR_WIDTH-1:0];
        s0_last_q   <= (index_q == IDX_LAST);
      end
    end
  end

  always_ff @(posedge pixel_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_valid_q <= 1'b0;
      s1_r_q     <= '0;
      s1_g_q     <= '0;
      s1_b_q     <= '0;
      s1_addr_q  <= '0;
      s1_last_q  <= 1'b0;
    end else begin
      s1_valid_q <= s0_valid_q;
      if (s0_valid_q) begin
        s1_r_q    <= scale(s0_r_q, s0_bright_q);
        s1_g_q    <= scale(s0_g_q, s0_bright_q);
        s1_b_q    <= scale(s0_b_q, s0_bright_q);
        s1_addr_q <= s0_addr_q;
        s1_last_q <= s0_last_q;
      end
    end
  end

  // Output register: data holds between strobes, truncating the product without rounding.
  always_ff @(posedge pixel_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      out_valid_q <= 1'b0;
      out_done_q  <= 1'b0;
      out_r_q     <= '0;
      out_g_q     <= '0;
      out_b_q     <= '0;
      out_addr_q  <= '0;
    end else begin
      out_valid_q <= s1_valid_q;
      out_done_q  <= s1_valid_q && s1_last_q;
      if (s1_valid_q) begin
        out_r_q    <= s1_r_q[15:8];
        out_g_q    <= s1_g_q[15:8];
        out_b_q    <= s1_b_q[15:8];
        out_addr_q <= s1_addr_q;
      end
    end
  end

  assign byte_ready_o        = ready_q;
  assign pixel_r_o           = out_r_q;
  assign pixel_g_o           = out_g_q;
  assign pixel_b_o           = out_b_q;
  assign led_address_o       = out_addr_q;
  assign led_address_valid_o = out_valid_q;
  assign frame_done_o        = out_done_q;
  assign overflow_o          = overflow_q;
  assign sync_err_o          = sync_err_q;

endmodule

// File: tb/tb_pixel_stream_loader.sv
// Bench for pixel_stream_loader: directed frames plus random bytes, checked against a
// byte-counting reference model that predicts every RAM write and its cycle.
module tb_pixel_stream_loader;

  localparam int N = 60;

  logic       pixel_clk_i = 1'b0;
  logic       rst_n_i;
  logic [7:0] byte_i;
  logic       byte_valid_i;
  logic       byte_ready_o;
  logic       sof_i;
  logic [7:0] brightness_i;
  logic [7:0] pixel_r_o, pixel_g_o, pixel_b_o;
  logic [8:0] led_address_o;
  logic       led_address_valid_o;
  logic       frame_done_o;
  logic       overflow_o;
  logic       sync_err_o;

  pixel_stream_loader #(.LED_COUNT(N), .ADDR_WIDTH(9)) dut (
    .pixel_clk_i         (pixel_clk_i),
    .rst_n_i             (rst_n_i),
    .byte_i              (byte_i),
    .byte_valid_i        (byte_valid_i),
    .byte_ready_o        (byte_ready_o),
    .sof_i               (sof_i),
    .brightness_i        (brightness_i),
    .pixel_r_o           (pixel_r_o),
    .pixel_g_o           (pixel_g_o),
    .pixel_b_o           (pixel_b_o),
    .led_address_o       (led_address_o),
    .led_address_valid_o (led_address_valid_o),
    .frame_done_o        (frame_done_o),
    .overflow_o          (overflow_o),
    .sync_err_o          (sync_err_o)
  );

  // clock / reset
  always #5 pixel_clk_i = ~pixel_clk_i;

  int cyc = 0;
  always @(posedge pixel_clk_i) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  // reference model: {cycle[65:34], last[33], addr[32:24], r[23:16], g[15:8], b[7:0]}
  logic [65:0] exp_q[$];
  int          se_q[$];
  logic [32:0] last_out;
  bit          m_synced;
  int          m_cnt;
  logic [7:0]  m_r, m_g;
  int          m_idx;
  bit          m_ovf;

  task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] scale(input int c, input int br);
    return 8'((c * (br + 1)) / 256);
  endfunction

  task automatic model_reset();
    m_synced = 1'b0;
    m_cnt    = 0;
    m_r      = '0;
    m_g      = '0;
    m_idx    = 0;
    m_ovf    = 1'b0;
    exp_q.delete();
    se_q.delete();
    last_out = '0;
  endtask

  task automatic model_byte(input logic [7:0] b, input bit sof, input logic [7:0] br, input int t);
    if (sof) begin
      if (m_synced && m_cnt != 0) se_q.push_back(t);
      m_synced = 1'b1;
      m_cnt    = 1;
      m_r      = b;
      m_idx    = 0;
      m_ovf    = 1'b0;
    end else if (m_synced) begin
      if (m_cnt == 0) begin
        m_r   = b;
        m_cnt = 1;
      end else if (m_cnt == 1) begin
        m_g   = b;
        m_cnt = 2;
      end else begin
        m_cnt = 0;
        if (m_idx < N) begin
          exp_q.push_back({32'(t + 2), (m_idx == N - 1), 9'(m_idx),
                           scale(int'(m_r), int'(br)), scale(int'(m_g), int'(br)),
                           scale(int'(b), int'(br))});
          m_idx++;
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
  endtask

  // driver tasks
  task automatic send(input logic [7:0] b, input bit sof, input logic [7:0] br);
    @(negedge pixel_clk_i);
    byte_i       = b;
    sof_i        = sof;
    brightness_i = br;
    byte_valid_i = 1'b1;
    model_byte(b, sof, br, cyc + 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge pixel_clk_i);
      byte_valid_i = 1'b0;
      byte_i       = 8'($urandom);
      sof_i        = 1'($urandom);
      brightness_i = 8'($urandom);
    end
  endtask

  task automatic pixel(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                       input logic [7:0] br, input bit sof, input int gap);
    send(r, sof, 8'($urandom));
    send(g, 1'b0, 8'($urandom));
    send(b, 1'b0, br);
    if (gap > 0) idle(gap);
  endtask

  task automatic do_reset();
    @(negedge pixel_clk_i);
    rst_n_i      = 1'b0;
    byte_valid_i = 1'b0;
    model_reset();
    #1;
    chk("reset_outputs", {byte_ready_o, led_address_valid_o, frame_done_o, overflow_o, sync_err_o,
                          led_address_o, pixel_r_o, pixel_g_o, pixel_b_o}, 66'd0);
    mon_en = 1'b1;
    repeat (3) @(negedge pixel_clk_i);
    rst_n_i = 1'b1;
    #1;
    chk("ready_before_first_edge", byte_ready_o, 1'b0);
    @(posedge pixel_clk_i);
    #2;
    chk("ready_after_first_edge", byte_ready_o, 1'b1);
  endtask

  // scoreboard / monitor
  logic [65:0] mon_e;
  bit          exp_se;
  always @(posedge pixel_clk_i) begin
    #1;
    if (mon_en) begin
      if (led_address_valid_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("write_expected", led_address_valid_o, 1'b0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("write_cycle", cyc, mon_e[65:34]);
          chk("write_addr", led_address_o, mon_e[32:24]);
          chk("write_r", pixel_r_o, mon_e[23:16]);
          chk("write_g", pixel_g_o, mon_e[15:8]);
          chk("write_b", pixel_b_o, mon_e[7:0]);
          chk("frame_done", frame_done_o, mon_e[33]);
          last_out = mon_e[32:0];
        end
      end else begin
        chk("data_hold", {led_address_o, pixel_r_o, pixel_g_o, pixel_b_o}, last_out);
        chk("frame_done_idle", frame_done_o, 1'b0);
        if (exp_q.size() > 0) begin
          mon_e = exp_q[0];
          if (int'(mon_e[65:34]) < cyc) begin
            chk("write_missing", led_address_valid_o, 1'b1);
            void'(exp_q.pop_front());
          end
        end
      end
      exp_se = (se_q.size() > 0) && (se_q[0] == cyc);
      if (exp_se) void'(se_q.pop_front());
      chk("sync_err", sync_err_o, exp_se);
      chk("overflow", overflow_o, m_ovf);
    end
  end

  initial begin
    rst_n_i      = 1'b1;
    byte_valid_i = 1'b0;
    byte_i       = '0;
    sof_i        = 1'b0;
    brightness_i = '0;
    model_reset();

    // first pixel at unity brightness
    do_reset();
    send(8'h10, 1'b1, 8'h00);
    send(8'h20, 1'b0, 8'h00);
    send(8'h30, 1'b0, 8'hFF);
    idle(4);

    // bytes before sync are dropped, then a full frame with random gaps
    do_reset();
    for (int i = 0; i < 6; i++) send(8'($urandom), 1'b0, 8'($urandom));
    idle(3);
    for (int i = 0; i < N; i++)
      pixel(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), (i == 0), $urandom_range(0, 1));
    idle(4);

    // brightness corner values, and a launched pixel surviving a following sof
    pixel(8'hFF, 8'h80, 8'h01, 8'd127, 1'b1, 0);
    pixel(8'hAB, 8'hCD, 8'hEF, 8'd0, 1'b0, 0);
    pixel(8'hFF, 8'hFF, 8'hFF, 8'd255, 1'b0, 0);
    pixel(8'h5A, 8'hA5, 8'h3C, 8'($urandom), 1'b1, 0);
    idle(4);

    // overflow: N+2 back-to-back triplets, then a new frame clears it
    for (int i = 0; i < N + 2; i++)
      pixel(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), (i == 0), 0);
    idle(4);
    chk("overflow_sticky", overflow_o, 1'b1);
    pixel(8'h01, 8'h02, 8'h03, 8'hFF, 1'b1, 4);

    // sof mid-pixel (during B phase and during G phase)
    send(8'h11, 1'b1, 8'hFF);
    send(8'h22, 1'b0, 8'hFF);
    send(8'h33, 1'b1, 8'hFF);
    send(8'h44, 1'b0, 8'hFF);
    send(8'h55, 1'b0, 8'hFF);
    idle(4);
    send(8'h66, 1'b1, 8'hFF);
    pixel(8'h77, 8'h88, 8'h99, 8'hFF, 1'b1, 4);

    // random byte stream with occasional sof
    for (int i = 0; i < 120; i++) begin
      send(8'($urandom), ($urandom_range(0, 11) == 0), 8'($urandom));
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(4);

    // reset between G and B drops the pixel; unsynced bytes dropped afterwards
    pixel(8'hC0, 8'hC1, 8'hC2, 8'hFF, 1'b1, 4);
    send(8'hD0, 1'b1, 8'hFF);
    send(8'hD1, 1'b0, 8'hFF);
    do_reset();
    for (int i = 0; i < 5; i++) send(8'($urandom), 1'b0, 8'hFF);
    idle(4);
    pixel(8'hE0, 8'hE1, 8'hE2, 8'd200, 1'b1, 0);
    idle(6);

    chk("writes_drained", exp_q.size(), 0);
    chk("sync_err_drained", se_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
